register_file: RTL
==================

Name: register_file

Overview:
Parametrised successor to the single 16-bit LOAD register. It is a bank of DEPTH registers, each WIDTH bits, with one write port, two independent read ports and write-through bypass. It also has a hardware clear sequencer that zeroes the bank one entry per cycle. It sits between the ALU and the control unit as the CPU's general-purpose register set.

Parameters:
WIDTH, 16, bit width of each register and of IN/OUT_A/OUT_B
DEPTH, 8, number of registers; must be >= 2
ADDR_W, $clog2(DEPTH) (3), address width; derived, never overridden independently

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous active-low reset
IN  input  WIDTH  write data
LOAD  input  1  write enable
WADDR  input  ADDR_W  write address
RADDR_A  input  ADDR_W  read address, port A
RADDR_B  input  ADDR_W  read address, port B
OUT_A  output  WIDTH  read data, port A (combinational)
OUT_B  output  WIDTH  read data, port B (combinational)
CLEAR  input  1  start bank-clear sweep (sampled on clock edge)
BUSY  output  1  high while the clear sweep is in progress

Behaviour:
- Reset (RST_N=0, asynchronous, immediate):
  - all DEPTH entries = 0
  - FSM = IDLE, sweep pointer = 0, BUSY = 0
  - consequently OUT_A = OUT_B = 0 (no bypass active while BUSY=0 and LOAD=0)
- Write:
  - on a CLK rising edge with LOAD=1 and BUSY=0: mem[WADDR] <= IN
  - WADDR >= DEPTH (non-power-of-2 DEPTH): write dropped, no entry changes
- Read:
  - combinational, zero-cycle latency: OUT_x = mem[RADDR_x]
  - RADDR_x >= DEPTH: OUT_x = 0
  - both ports may address the same entry, or any entries, independently
- Bypass:
  - if LOAD=1, BUSY=0, WADDR==RADDR_x and WADDR < DEPTH, then OUT_x = IN in the same cycle (write-through)
  - applies to both ports simultaneously when both match
- Clear FSM (states IDLE, SWEEP):
  - IDLE, CLEAR=1 at edge -> SWEEP; ptr <= 0; BUSY = 1 from the following cycle
  - LOAD=1 in that same edge is still honoured; the sweep zeroes that entry later
  - SWEEP, each edge: mem[ptr] <= 0; ptr <= ptr+1
    - when ptr==DEPTH-1 is cleared -> IDLE, BUSY=0
    - BUSY is high for exactly DEPTH cycles
  - During SWEEP:
    - LOAD ignored (write dropped, no bypass)
    - CLEAR ignored (no restart)
    - reads return the current array contents: already-cleared entries read 0, uncleared entries keep their old value
- Reset asserted mid-sweep: immediate full clear; FSM IDLE; BUSY=0; the sweep does not resume after reset deasserts
- All state changes on the CLK rising edge only, except the asynchronous reset
- No X may propagate to OUT_A/OUT_B/BUSY after reset for any legal input

Test Plan:
1. Reset, then LOAD=1 WADDR=3 IN=16'h0C0C, next cycle LOAD=0 RADDR_A=3 -> OUT_A=16'h0C0C; RADDR_B=4 -> OUT_B=0.
2. LOAD=1 WADDR=5 IN=16'hBEEF with RADDR_A=RADDR_B=5 before the edge -> OUT_A=OUT_B=16'hBEEF combinationally; after the edge with LOAD=0 -> still 16'hBEEF from storage.
3. Fill entries 0..7 with 16'h1111*i, then pulse CLEAR one cycle:
   - BUSY=1 for exactly 8 cycles
   - mid-sweep, after 4 sweep edges: RADDR_A=2 -> 0 and RADDR_B=6 -> 16'h6666
   - after BUSY falls, all entries read 0
4. During SWEEP, LOAD=1 WADDR=7 IN=16'hFFFF with RADDR_A=7 -> no bypass (OUT_A=16'h7777 until cleared, then 0); entry 7 = 0 after the sweep.
5. LOAD=1 and CLEAR=1 in the same IDLE cycle (WADDR=0, IN=16'hA5A5) -> entry 0 reads 16'hA5A5 one cycle, then 0 after the first sweep edge; a second CLEAR pulse mid-sweep does not extend BUSY beyond 8 cycles.
6. Assert RST_N=0 asynchronously (between clock edges) mid-sweep with entries nonzero -> OUT_A/OUT_B=0 and BUSY=0 immediately; after release, LOAD works on the next edge.

Source files
------------

// File: rtl/register_file.sv
// General-purpose register bank: one write port, two combinational read ports with
// write-through bypass, and a one-entry-per-cycle hardware clear sweep.
module register_file #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [WIDTH-1:0]  IN,
    input  logic              LOAD,
    input  logic [ADDR_W-1:0] WADDR,
    input  logic [ADDR_W-1:0] RADDR_A,
    input  logic [ADDR_W-1:0] RADDR_B,
    output logic [WIDTH-1:0]  OUT_A,
    output logic [WIDTH-1:0]  OUT_B,
    input  logic              CLEAR,
    output logic              BUSY,
    output logic [0:0]        state_dbg
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SWEEP = 1'b1;

    localparam logic [ADDR_W-1:0] LAST_ENTRY = ADDR_W'(DEPTH - 1);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [0:0]        state;
    logic [ADDR_W-1:0] ptr;

    logic waddr_ok;
    logic raddr_a_ok;
    logic raddr_b_ok;
    logic wr_en;
    logic bypass_a;
    logic bypass_b;

    // Address range checks only exist when DEPTH leaves unused codes in the address space.
    generate
        if (DEPTH == (1 << ADDR_W)) begin : g_full_range
            assign waddr_ok   = 1'b1;
            assign raddr_a_ok = 1'b1;
            assign raddr_b_ok = 1'b1;
        end else begin : g_partial_range
            localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
            assign waddr_ok   = ({1'b0, WADDR}   < DEPTH_W);
            assign raddr_a_ok = ({1'b0, RADDR_A} < DEPTH_W);
            assign raddr_b_ok = ({1'b0, RADDR_B} < DEPTH_W);
        end
    endgenerate

    assign BUSY      = (state == S_SWEEP);
    assign state_dbg = state;

    // The sweep owns the array: writes and bypass are suppressed while it runs.
    assign wr_en    = LOAD && !BUSY && waddr_ok;
    assign bypass_a = wr_en && (WADDR == RADDR_A);
    assign bypass_b = wr_en && (WADDR == RADDR_B);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
            ptr   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (CLEAR) begin
                        state <= S_SWEEP;
                        ptr   <= '0;
                    end
                end
                S_SWEEP: begin
                    if (ptr == LAST_ENTRY) begin
                        state <= S_IDLE;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    ptr   <= '0;
                end
            endcase
        end
    end

    // A write on the same edge that starts the sweep still lands; the sweep clears it later.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (BUSY) begin
            mem[ptr] <= '0;
        end else if (wr_en) begin
            mem[WADDR] <= IN;
        end
    end

    always_comb begin
        OUT_A = '0;
        if (bypass_a) begin
            OUT_A = IN;
        end else if (raddr_a_ok) begin
            OUT_A = mem[RADDR_A];
        end
    end

    always_comb begin
        OUT_B = '0;
        if (bypass_b) begin
            OUT_B = IN;
        end else if (raddr_b_ok) begin
            OUT_B = mem[RADDR_B];
        end
    end

endmodule
